// File: rtl/f_divsqrt_if.sv
// Issue/return bundle for the f_divsqrt divide/sqrt unit.
//   master (FP issue logic): START, OP, DATA1, DATA2  ->  BUSY, VALID, RESULT, FFLAGS
//   slave  (f_divsqrt)     : the same signals with the directions reversed
interface f_divsqrt_if;
  logic        START;
  logic        OP;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RESULT;
  logic [4:0]  FFLAGS;

  modport master (output START, OP, DATA1, DATA2,
                  input  BUSY, VALID, RESULT, FFLAGS);
  modport slave  (input  START, OP, DATA1, DATA2,
                  output BUSY, VALID, RESULT, FFLAGS);
endinterface

// File: rtl/f_divsqrt.sv
// Iterative single-precision FDIV.S / FSQRT.S unit, round-toward-zero,
// subnormals flushed to zero. One result bit is produced per ITER cycle.
// Ports:
//   CLK    - rising-edge clock
//   RESET  - synchronous active-high reset, aborts any operation
//   bus    - f_divsqrt_if.slave: START/OP/DATA1/DATA2 in,
//            BUSY/VALID/RESULT/FFLAGS ({NV,DZ,OF,UF,NX}) out
module f_divsqrt #(
  parameter logic [31:0] CANONICAL_NAN = 32'h7FC00000
) (
  input  logic         CLK,
  input  logic         RESET,
  f_divsqrt_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, NORM} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               op_q, op_d, sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [27:0]        rem_q, rem_d;
  logic [24:0]        q_q, q_d;
  logic [23:0]        div_q, div_d;
  logic [49:0]        rad_q, rad_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               valid_q, valid_d;

  // Pack a normalized RTZ result, saturating to max-finite on overflow and
  // flushing to signed zero on underflow. Returns {fflags, result}.
  function automatic logic [36:0] pack_rtz(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] m, input logic nx);
    if (e >= 10'sd255)    return {5'b00101, s, 31'h7F7FFFFF};
    else if (e <= 10'sd0) return {5'b00011, s, 31'h00000000};
    else                  return {4'b0000, nx, s, e[7:0], m[22:0]};
  endfunction

  // Operand unpack and classification (exponent 0 counts as zero).
  logic       sa, sb, sq;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  logic       zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  assign sa     = a_q[31];
  assign sb     = b_q[31];
  assign sq     = sa ^ sb;
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign ma     = {1'b1, a_q[22:0]};
  assign mb     = {1'b1, b_q[22:0]};
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);
  assign inf_a  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign inf_b  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign nan_a  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign snan_a = nan_a && !a_q[22];
  assign snan_b = nan_b && !b_q[22];

  logic        special;
  logic [31:0] spec_res;
  logic [4:0]  spec_flg;

  always_comb begin
    special  = 1'b1;
    spec_res = CANONICAL_NAN;
    spec_flg = 5'b00000;
    if (op_q) begin
      if (nan_a)       spec_flg = {snan_a, 4'b0000};
      else if (zero_a) spec_res = {sa, 31'h0};
      else if (sa)     spec_flg = 5'b10000;
      else if (inf_a)  spec_res = 32'h7F800000;
      else             special  = 1'b0;
    end else begin
      if (nan_a || nan_b)                               spec_flg = {snan_a | snan_b, 4'b0000};
      else if ((zero_a && zero_b) || (inf_a && inf_b))  spec_flg = 5'b10000;
      else if (inf_a)  spec_res = {sq, 31'h7F800000};
      else if (inf_b)  spec_res = {sq, 31'h0};
      else if (zero_b) begin
        spec_res = {sq, 31'h7F800000};
        spec_flg = 5'b01000;
      end
      else if (zero_a) spec_res = {sq, 31'h0};
      else             special  = 1'b0;
    end
  end

  // Sqrt exponent: (E-127) made even, halved, rebiased == (E + 126 + E[0]) / 2.
  logic [9:0]        sqrt_exp;
  logic signed [9:0] div_exp;
  logic [24:0]       sqrt_x;
  assign sqrt_exp = ({2'b00, ea} + 10'd126 + {9'd0, ea[0]}) >> 1;
  assign div_exp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  // Odd unbiased exponent (even E) doubles the radicand.
  assign sqrt_x   = ea[0] ? {1'b0, ma} : {ma, 1'b0};

  // One iteration step: restoring divide or restoring digit-by-digit root.
  logic [27:0] rem_t, trial;
  logic        step_ge;
  assign rem_t   = {rem_q[25:0], rad_q[49:48]};
  assign trial   = {1'b0, q_q, 2'b01};
  assign step_ge = op_q ? (rem_t >= trial) : (rem_q >= {4'b0000, div_q});

  // Normalization: a quotient below 1 has its leading one at bit 23.
  logic [23:0]       n_mant;
  logic              n_lost;
  logic signed [9:0] n_exp;

  always_comb begin
    n_mant = q_q[24:1];
    n_lost = q_q[0];
    n_exp  = exp_q;
    if (!op_q && !q_q[24]) begin
      n_mant = q_q[23:0];
      n_lost = 1'b0;
      n_exp  = exp_q - 10'sd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    q_d      = q_q;
    div_d    = div_q;
    rad_d    = rad_q;
    result_d = result_q;
    fflags_d = fflags_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          a_d     = bus.DATA1;
          b_d     = bus.DATA2;
          op_d    = bus.OP;
          state_d = PREP;
        end
      end
      PREP: begin
        if (special) begin
          result_d = spec_res;
          fflags_d = spec_flg;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d   = 5'd0;
          q_d     = 25'd0;
          state_d = ITER;
          if (op_q) begin
            sign_d = 1'b0;
            exp_d  = $signed(sqrt_exp);
            rem_d  = 28'd0;
            rad_d  = {sqrt_x, 25'd0};
          end else begin
            sign_d = sq;
            exp_d  = div_exp;
            rem_d  = {4'b0000, ma};
            div_d  = mb;
          end
        end
      end
      ITER: begin
        q_d = {q_q[23:0], step_ge};
        if (op_q) begin
          rem_d = step_ge ? (rem_t - trial) : rem_t;
          rad_d = {rad_q[47:0], 2'b00};
        end else begin
          rem_d = (step_ge ? (rem_q - {4'b0000, div_q}) : rem_q) << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        {fflags_d, result_d} = pack_rtz(sign_q, n_exp, n_mant, n_lost | (rem_q != 28'd0));
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      valid_q  <= 1'b0;
      result_q <= 32'd0;
      fflags_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
    a_q    <= a_d;
    b_q    <= b_d;
    op_q   <= op_d;
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rem_q  <= rem_d;
    q_q    <= q_d;
    div_q  <= div_d;
    rad_q  <= rad_d;
  end

  assign bus.BUSY   = (state_q != IDLE);
  assign bus.VALID  = valid_q;
  assign bus.RESULT = result_q;
  assign bus.FFLAGS = fflags_q;

endmodule

// File: tb/tb_f_divsqrt.sv
// Directed bench for f_divsqrt: arithmetic vectors, specials,
// overflow/underflow, handshake behaviour and mid-operation reset.
module tb_f_divsqrt;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  f_divsqrt_if bus ();

  f_divsqrt #(.CANONICAL_NAN(32'h7FC00000)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one START at a negedge; returns just after the accepting edge E0.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.DATA1 = a;
    bus.DATA2 = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  // Counts edges until VALID is seen (bounded), noting any idle BUSY on the way.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.VALID && lat < 60) begin
      if (!bus.BUSY) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic [4:0] ef, input int elat);
    int lat;
    bit busy_ok;
    issue(op, a, b);
    wait_valid(lat, busy_ok);
    chk({tag, "_lat"},  32'(lat), 32'(elat));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_in_valid"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_res"},  bus.RESULT, er);
    chk({tag, "_flags"}, 32'(bus.FFLAGS), 32'(ef));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(bus.VALID), 32'd0);
  endtask

  initial begin
    int lat, cnt, cyc, nv;
    bit busy_ok;
    int vedge[3];

    bus.START = 1'b0;
    bus.OP    = 1'b0;
    bus.DATA1 = 32'd0;
    bus.DATA2 = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.BUSY), 32'd0);
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    chk("rst_res",   bus.RESULT, 32'd0);
    chk("rst_flags", 32'(bus.FFLAGS), 32'd0);
    rst = 1'b0;

    do_op("div_6_2",   1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27);
    do_op("div_1_3",   1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00001, 27);
    do_op("sqrt_4",    1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 5'b00000, 27);
    do_op("sqrt_2",    1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 27);
    do_op("div_by0",   1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    do_op("div_0_0",   1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    do_op("sqrt_neg",  1'b1, 32'hBF800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    do_op("sqrt_m0",   1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000, 1);
    do_op("div_ovf",   1'b0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F7FFFFF, 5'b00101, 27);
    do_op("div_unf",   1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 27);
    do_op("div_subn",  1'b0, 32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 1);
    do_op("div_snan",  1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    do_op("div_qnan",  1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
    do_op("div_ninf",  1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
    do_op("div_x_inf", 1'b0, 32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 1);

    // START pulsed while a divide is in flight must be ignored.
    issue(1'b0, 32'h40C00000, 32'h40000000);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    bus.START = 1'b1;
    bus.DATA1 = 32'h3F800000;
    bus.DATA2 = 32'h40400000;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    wait_valid(lat, busy_ok);
    chk("ign_lat", 32'(lat), 32'd22);
    chk("ign_res", bus.RESULT, 32'h40400000);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.VALID) cnt++;
    end
    chk("ign_extra_valid", 32'(cnt), 32'd0);

    // START held high: a new divide is accepted in every VALID cycle.
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = 1'b0;
    bus.DATA1 = 32'h40C00000;
    bus.DATA2 = 32'h40000000;
    cyc = 0;
    nv  = 0;
    while (nv < 3 && cyc < 120) begin
      @(posedge clk);
      #1;
      if (bus.VALID) begin
        vedge[nv] = cyc;
        chk("held_res", bus.RESULT, 32'h40400000);
        nv++;
      end
      cyc++;
    end
    bus.START = 1'b0;
    chk("held_count", 32'(nv), 32'd3);
    chk("held_v0", 32'(vedge[0]), 32'd27);
    chk("held_v1", 32'(vedge[1]), 32'd55);
    chk("held_v2", 32'(vedge[2]), 32'd83);
    @(posedge clk);
    #1;
    chk("held_idle", 32'(bus.BUSY), 32'd0);

    // Reset at cycle 10 of a divide aborts it without a VALID.
    issue(1'b0, 32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy",  32'(bus.BUSY), 32'd0);
    chk("abort_valid", 32'(bus.VALID), 32'd0);
    chk("abort_res",   bus.RESULT, 32'd0);
    chk("abort_flags", 32'(bus.FFLAGS), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.VALID) cnt++;
    end
    chk("abort_no_valid", 32'(cnt), 32'd0);
    do_op("after_abort", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00001, 27);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
